pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
// - Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC.
// - Advances the whole pipeline only when the instruction fetch and any MEM-stage data access have both
//   completed, whichever order the hits arrive in.
// - Inserts load-use bubbles, flushes wrong-path instructions on a taken branch/jump and freezes on halt.
// PARAMETERS
// - CNT_W  16  width of the saturating stall-cycle counter
// PORTS
// - CLK           in   1      clock, rising edge
// - nRST          in   1      asynchronous active-low reset
// - ihit          in   1      instruction fetch complete this cycle
// - dhit          in   1      data access complete this cycle
// - mm_dREN       in   1      MEM-stage instruction is a load
// - mm_dWEN       in   1      MEM-stage instruction is a store
// - load_use      in   1      ID instruction depends on the load currently in EX
// - br_taken      in   1      redirect (branch/jump) resolved in MEM stage
// - wb_halt       in   1      halt instruction has reached WB
// - pc_en         out  1      PC update enable
// - ifid_en, idex_en, exmem_en, mmwb_en       out 1 each  stage register enables
// - ifid_flush, idex_flush, exmem_flush       out 1 each  load a bubble instead of stage input
// - dmemREN, dmemWEN   out  1  gated data-memory request
// - halted        out  1      core halted (sticky)
// - stall_cnt     out  CNT_W  cycles in which the pipeline did not advance (saturating)
// BEHAVIOUR
// - Reset while nRST=0: state=RUN, ifd=0, halted=0, stall_cnt=0. All enables, flushes and dmem* are
//   forced to 0. Reset mid-wait abandons any outstanding access; no replay.
// - dacc = mm_dREN | mm_dWEN. ifd = 1-bit register that records an ihit seen while waiting on data.
// - States (ctrl_state_t):
//   - RUN: no partial completion recorded.
//   - DWAIT: waiting on dhit; ifd holds the ihit status.
//   - IWAIT: dhit received, waiting on ihit.
//   - HALT: terminal.
// - dmemREN/dmemWEN = mm_dREN/mm_dWEN in RUN and DWAIT; 0 in IWAIT and HALT. This prevents a duplicate
//   store after dhit.
// - adv (combinational):
//   - RUN: ihit & (~dacc | dhit)
//   - DWAIT: dhit & (ifd | ihit)
//   - IWAIT: ihit
//   - HALT: 0
// - Transitions:
//   - RUN: dacc & ~dhit -> DWAIT, with ifd <= ihit. dacc & dhit & ~ihit -> IWAIT.
//   - DWAIT: dhit & ~(ifd | ihit) -> IWAIT. Otherwise ifd <= ifd | ihit.
//   - Any adv -> RUN, with ifd <= 0.
// - Enables when adv=1:
//   - pc_en = ifid_en = idex_en = exmem_en = mmwb_en = 1
//   - load_use=1 (and br_taken=0): pc_en = ifid_en = 0, idex_flush = 1. One bubble; exmem/mmwb still advance.
//   - br_taken=1 (priority over load_use): pc_en = 1, ifid_flush = idex_flush = exmem_flush = 1.
// - When adv=0: all enables and flushes are 0; stall_cnt increments, saturating at all-ones.
// - Flushes are only ever asserted together with the matching enable.
// - Halt:
//   - wb_halt=1 in any non-HALT state -> HALT next cycle; halted <= 1.
//   - In the wb_halt cycle: pc_en = 0 and all enables/flushes = 0. WB of the halt instruction has already
//     been committed by the register file.
//   - HALT is exited only by reset. stall_cnt does not count in HALT.
// - Simultaneous events:
//   - wb_halt overrides adv.
//   - ihit and dhit in the same cycle in RUN advance with zero stall.
//   - dhit without dacc is ignored.
// STRUCTURE
// - ctrl_state_t enum {RUN, DWAIT, IWAIT, HALT} is added to control_unit_types_pkg.
// - Single module; no sub-module. State register, ifd register and the counter live in one always_ff.
//   Next-state and output logic live in one always_comb.
// TESTING
// - Reset: hold nRST=0 with ihit=1 -> all enables 0, stall_cnt=0, halted=0. Release -> RUN.
// - No mem access, ihit=1 for 5 cycles -> all *_en=1 every cycle, stall_cnt=0.
// - Load, dhit before ihit:
//   - Stimulus: mm_dREN=1; dhit at cycle 0, ihit at cycle 3.
//   - Cycle 0 -> IWAIT; dmemREN drops to 0 from cycle 1.
//   - adv at cycle 3; stall_cnt=3.
// - Store, ihit before dhit:
//   - Stimulus: mm_dWEN=1; ihit at cycle 0, dhit at cycle 2.
//   - DWAIT with ifd=1; dmemWEN held 1 through cycle 2.
//   - adv at cycle 2; stall_cnt=2.
// - load_use=1 with ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=mmwb_en=1.
//   Same cycle with br_taken=1 -> three flushes, pc_en=1.
// - Halt and saturation:
//   - wb_halt=1 -> next cycle halted=1, all enables 0 for 10 further cycles despite ihit/dhit.
//   - CNT_W=4 with 20 stalled cycles -> stall_cnt=15.

Source files
------------

// File: rtl/control_unit_types_pkg.sv
// Shared types for the control unit: pipeline sequencer states and defaults.
package control_unit_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    HALT  = 2'd3
  } ctrl_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: joins ifetch and data completions,
// inserts load-use bubbles, flushes on redirect and freezes on halt.
module pipeline_ctrl
  import control_unit_types_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mm_dREN,
  input  logic             mm_dWEN,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             mmwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_state_t      state_reg, state_next;
  logic             ifd_reg, ifd_next;
  logic             halted_reg, halted_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             dacc;
  logic             adv;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= RUN;
      ifd_reg       <= 1'b0;
      halted_reg    <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ifd_reg       <= ifd_next;
      halted_reg    <= halted_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_comb begin
    dacc           = mm_dREN | mm_dWEN;
    adv            = 1'b0;
    state_next     = state_reg;
    ifd_next       = ifd_reg;
    halted_next    = halted_reg;
    stall_cnt_next = stall_cnt_reg;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    mmwb_en        = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    dmemREN        = 1'b0;
    dmemWEN        = 1'b0;

    unique case (state_reg)
      RUN: begin
        adv     = ihit & (~dacc | dhit);
        dmemREN = mm_dREN;
        dmemWEN = mm_dWEN;
        if (dacc && !dhit) begin
          state_next = DWAIT;
          ifd_next   = ihit;
        end else if (dacc && dhit && !ihit) begin
          state_next = IWAIT;
        end
      end
      DWAIT: begin
        adv     = dhit & (ifd_reg | ihit);
        dmemREN = mm_dREN;
        dmemWEN = mm_dWEN;
        if (dhit && !(ifd_reg || ihit))
          state_next = IWAIT;
        else
          ifd_next = ifd_reg | ihit;
      end
      // Data already completed: the request is dropped so a store is not repeated.
      IWAIT: adv = ihit;
      HALT:  adv = 1'b0;
      default: adv = 1'b0;
    endcase

    if (state_reg != HALT && wb_halt) begin
      adv         = 1'b0;
      state_next  = HALT;
      halted_next = 1'b1;
    end else if (adv) begin
      state_next = RUN;
      ifd_next   = 1'b0;
    end

    if (adv) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      mmwb_en  = 1'b1;
      if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    if (state_reg != HALT && !adv && stall_cnt_reg != {CNT_W{1'b1}})
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);

    // Outputs are held quiet for the whole time reset is asserted.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      mmwb_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      dmemREN     = 1'b0;
      dmemWEN     = 1'b0;
    end
  end

  assign halted    = halted_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a completion-flag reference model; a CNT_W=4 copy checks counter saturation.
module tb_pipeline_ctrl;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, mm_dREN, mm_dWEN, load_use, br_taken, wb_halt;

  logic pc_en, ifid_en, idex_en, exmem_en, mmwb_en;
  logic ifid_flush, idex_flush, exmem_flush, dmemREN, dmemWEN, halted;
  logic [15:0] stall_cnt;

  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, mmwb_en_s;
  logic ifid_flush_s, idex_flush_s, exmem_flush_s, dmemREN_s, dmemWEN_s, halted_s;
  logic [3:0] stall_cnt_s;

  logic [7:0]  obs_ctl, obs_ctl_s;
  logic [10:0] obs_all, obs_all_s;

  int checks = 0;
  int errors = 0;

  // Reference model: completion flags since the last advance.
  bit         m_i_done, m_d_done, m_halted;
  int         m_cnt;
  bit         e_adv;
  logic [7:0] e_ctl;
  logic       e_dren, e_dwen;
  logic [10:0] e_all;
  logic [15:0] e_cnt16;
  logic [3:0]  e_cnt4;

  always #5 CLK = ~CLK;

  assign obs_ctl   = {pc_en, ifid_en, idex_en, exmem_en, mmwb_en, ifid_flush, idex_flush, exmem_flush};
  assign obs_ctl_s = {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, mmwb_en_s,
                      ifid_flush_s, idex_flush_s, exmem_flush_s};
  assign obs_all   = {obs_ctl, dmemREN, dmemWEN, halted};
  assign obs_all_s = {obs_ctl_s, dmemREN_s, dmemWEN_s, halted_s};

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mm_dREN(mm_dREN), .mm_dWEN(mm_dWEN),
    .load_use(load_use), .br_taken(br_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .mmwb_en(mmwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_small (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mm_dREN(mm_dREN), .mm_dWEN(mm_dWEN),
    .load_use(load_use), .br_taken(br_taken), .wb_halt(wb_halt),
    .pc_en(pc_en_s), .ifid_en(ifid_en_s), .idex_en(idex_en_s), .exmem_en(exmem_en_s),
    .mmwb_en(mmwb_en_s), .ifid_flush(ifid_flush_s), .idex_flush(idex_flush_s),
    .exmem_flush(exmem_flush_s), .dmemREN(dmemREN_s), .dmemWEN(dmemWEN_s),
    .halted(halted_s), .stall_cnt(stall_cnt_s)
  );

  task automatic model_clear();
    m_i_done = 0; m_d_done = 0; m_halted = 0; m_cnt = 0;
  endtask

  task automatic model_eval();
    bit dacc;
    dacc  = mm_dREN | mm_dWEN;
    e_adv = nRST && !m_halted && !wb_halt && (m_i_done || ihit) && (!dacc || m_d_done || dhit);
    if (!e_adv)        e_ctl = 8'b00000000;
    else if (br_taken) e_ctl = 8'b11111111;
    else if (load_use) e_ctl = 8'b00111010;
    else               e_ctl = 8'b11111000;
    e_dren  = nRST && !m_halted && mm_dREN && !m_d_done;
    e_dwen  = nRST && !m_halted && mm_dWEN && !m_d_done;
    e_all   = {e_ctl, e_dren, e_dwen, m_halted};
    e_cnt16 = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    e_cnt4  = (m_cnt > 15) ? 4'hF : 4'(m_cnt);
  endtask

  task automatic model_update();
    model_eval();
    if (!nRST) begin
      model_clear();
    end else if (!m_halted) begin
      if (wb_halt) begin
        m_halted = 1;
        m_cnt++;
      end else if (e_adv) begin
        m_i_done = 0;
        m_d_done = 0;
      end else begin
        m_cnt++;
        if (ihit) m_i_done = 1;
        if ((mm_dREN || mm_dWEN) && dhit) m_d_done = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit i, input bit d, input bit r, input bit w,
                        input bit lu, input bit br, input bit h);
    ihit = i; dhit = d; mm_dREN = r; mm_dWEN = w; load_use = lu; br_taken = br; wb_halt = h;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    model_clear();
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1, 1, 1, 1, 0, 0, 0);
    nRST = 1'b0;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (obs_all !== 11'd0 || stall_cnt !== 16'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d outputs=%h cnt=%0d required outputs=0 cnt=0", c, obs_all, stall_cnt);
      end
      tick();
    end
    nRST = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    checks++;
    if (obs_all !== {8'b11111000, 3'b000} || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_release outputs=%h cnt=%0d required outputs=7c0 cnt=0", obs_all, stall_cnt);
    end
    tick();
  endtask

  task automatic test_no_mem();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      checks++;
      if (obs_ctl !== 8'b11111000 || stall_cnt !== 16'd0) begin
        errors++;
        $display("FAIL no_mem cyc%0d ctl=%b cnt=%0d required ctl=11111000 cnt=0", c, obs_ctl, stall_cnt);
      end
      tick();
    end
  endtask

  task automatic test_load_dhit_first();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(c == 3, c == 0, 1, 0, 0, 0, 0);
      @(negedge CLK);
      checks++;
      if (dmemREN !== (c == 0) || obs_ctl !== ((c == 3) ? 8'b11111000 : 8'b0)) begin
        errors++;
        $display("FAIL load_dfirst cyc%0d dmemREN=%b ctl=%b required dmemREN=%b ctl=%b",
                 c, dmemREN, obs_ctl, c == 0, (c == 3) ? 8'b11111000 : 8'b0);
      end
      if (c == 3) begin
        checks++;
        if (stall_cnt !== 16'd3) begin
          errors++;
          $display("FAIL load_dfirst_cnt got %0d required 3", stall_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_store_ihit_first();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(c == 0, c == 2, 0, 1, 0, 0, 0);
      @(negedge CLK);
      checks++;
      if (dmemWEN !== 1'b1 || obs_ctl !== ((c == 2) ? 8'b11111000 : 8'b0)) begin
        errors++;
        $display("FAIL store_ifirst cyc%0d dmemWEN=%b ctl=%b required dmemWEN=1 ctl=%b",
                 c, dmemWEN, obs_ctl, (c == 2) ? 8'b11111000 : 8'b0);
      end
      if (c == 2) begin
        checks++;
        if (stall_cnt !== 16'd2) begin
          errors++;
          $display("FAIL store_ifirst_cnt got %0d required 2", stall_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use_branch();
    do_reset();
    set_in(1, 0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    checks++;
    if (obs_ctl !== 8'b00111010) begin
      errors++;
      $display("FAIL load_use ctl=%b required 00111010", obs_ctl);
    end
    tick();
    set_in(1, 0, 0, 0, 1, 1, 0);
    @(negedge CLK);
    checks++;
    if (obs_ctl !== 8'b11111111) begin
      errors++;
      $display("FAIL branch_over_load_use ctl=%b required 11111111", obs_ctl);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) tick();
    @(negedge CLK);
    checks++;
    if (stall_cnt_s !== 4'hF || stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL saturation cnt4=%0d cnt16=%0d required cnt4=15 cnt16=20", stall_cnt_s, stall_cnt);
    end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 1, 1, 0, 0, 0, 1);
    @(negedge CLK);
    checks++;
    if (obs_ctl !== 8'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_cycle ctl=%b halted=%b required ctl=0 halted=0", obs_ctl, halted);
    end
    tick();
    for (int c = 0; c < 11; c++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom), 0);
      @(negedge CLK);
      model_eval();
      checks++;
      if (obs_all !== {8'b0, 3'b001} || stall_cnt !== 16'd2) begin
        errors++;
        $display("FAIL halted cyc%0d outputs=%h cnt=%0d required outputs=001 cnt=2", c, obs_all, stall_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit new_instr;
    bit rd, wr;
    do_reset();
    new_instr = 1;
    rd = 0; wr = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        nRST = 1'b0;
        model_clear();
        @(negedge CLK);
        checks++;
        if (obs_all !== 11'd0 || stall_cnt !== 16'd0) begin
          errors++;
          $display("FAIL rand_reset cyc%0d outputs=%h cnt=%0d required 0", c, obs_all, stall_cnt);
        end
        tick();
        nRST = 1'b1;
        new_instr = 1;
      end
      if (new_instr) begin
        case ($urandom_range(0, 2))
          0: begin rd = 0; wr = 0; end
          1: begin rd = 1; wr = 0; end
          default: begin rd = 0; wr = 1; end
        endcase
      end
      set_in(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), rd, wr,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), 0);
      @(negedge CLK);
      model_eval();
      checks++;
      if (obs_all !== e_all || obs_all_s !== e_all) begin
        errors++;
        $display("FAIL rand_outputs cyc%0d got=%h small=%h required=%h", c, obs_all, obs_all_s, e_all);
      end
      checks++;
      if (stall_cnt !== e_cnt16 || stall_cnt_s !== e_cnt4) begin
        errors++;
        $display("FAIL rand_stall_cnt cyc%0d got=%0d/%0d required=%0d/%0d",
                 c, stall_cnt, stall_cnt_s, e_cnt16, e_cnt4);
      end
      new_instr = e_adv;
      tick();
    end
  endtask

  initial begin
    nRST = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    test_reset();
    test_no_mem();
    test_load_dhit_first();
    test_store_ihit_first();
    test_load_use_branch();
    test_saturation();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
